// File: rtl/led_matrix_scanner_if.sv
// Host-side bundle for led_matrix_scanner: scan control, back-buffer write
// port, swap handshake and the matrix pin outputs.
interface led_matrix_scanner_if #(
   parameter int N_MAT  = 2,
   parameter int N_COLS = 8,
   parameter int N_ROWS = 8
);
   localparam int MW = (N_MAT > 1) ? $clog2(N_MAT) : 1;
   localparam int CW = $clog2(N_COLS);

   logic                     enable;
   logic                     wr_en;
   logic [MW-1:0]            wr_mat;
   logic [CW-1:0]            wr_col;
   logic [N_ROWS-1:0]        wr_data;
   logic                     swap_req;
   logic                     swap_ack;
   logic                     frame_start;
   logic [N_ROWS-1:0]        row;
   logic [N_MAT*N_COLS-1:0]  col;

   modport master (
      output enable, wr_en, wr_mat, wr_col, wr_data, swap_req,
      input  swap_ack, frame_start, row, col
   );

   modport slave (
      input  enable, wr_en, wr_mat, wr_col, wr_data, swap_req,
      output swap_ack, frame_start, row, col
   );
endinterface

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed scan driver for N_MAT LED matrices on a shared row bus.
// Double-buffered frame store; the host fills the back buffer and the swap
// is deferred to the frame boundary so a partial frame is never shown.
module led_matrix_scanner #(
   parameter int N_MAT     = 2,
   parameter int N_COLS    = 8,
   parameter int N_ROWS    = 8,
   parameter int TICK_DIV  = 16384,
   parameter int BLANK_CYC = 1
) (
   input logic                 clk,
   input logic                 reset,
   led_matrix_scanner_if.slave bus
);
   localparam int MW = (N_MAT > 1) ? $clog2(N_MAT) : 1;
   localparam int CW = $clog2(N_COLS);
   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLANK_CYC + 2);
   localparam int NB = N_MAT * N_COLS;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MAT_MAX   = MW'(N_MAT - 1);
   localparam logic [CW-1:0] COL_MAX   = CW'(N_COLS - 1);
   localparam logic [MW:0]   MAT_LIM   = (MW + 1)'(N_MAT);
   localparam logic [CW:0]   COL_LIM   = (CW + 1)'(N_COLS);
   localparam logic [BW-1:0] BLANK_LIM = BW'(BLANK_CYC);

   // scan position and blanking state
   logic [PW-1:0]     r_presc;
   logic [MW-1:0]     r_slot_mat;
   logic [CW-1:0]     r_slot_col;
   logic [BW-1:0]     r_bcnt;
   // frame store: index 0/1 is the buffer, r_front selects the displayed one
   logic [N_ROWS-1:0] r_buf [0:1][0:N_MAT-1][0:N_COLS-1];
   logic              r_front;
   logic              r_pend;
   // registered pin outputs
   logic [N_ROWS-1:0] r_row;
   logic [NB-1:0]     r_col_en;
   logic              r_swap_ack;
   logic              r_frame_start;

   logic              w_tick;
   logic              w_mat_wrap;
   logic              w_frame_end;
   logic              w_do_swap;
   logic              w_lit;
   logic              w_wr_ok;
   logic [NB-1:0]     w_col_sel;
   logic [N_ROWS-1:0] w_row_next;

   assign w_tick      = bus.enable & (r_presc == PRESC_MAX);
   assign w_mat_wrap  = (r_slot_mat == MAT_MAX);
   assign w_frame_end = w_tick & w_mat_wrap & (r_slot_col == COL_MAX);
   // a request arriving on the frame-end cycle itself is honoured immediately
   assign w_do_swap   = w_frame_end & (r_pend | bus.swap_req);
   assign w_lit       = bus.enable & (r_bcnt >= BLANK_LIM);
   assign w_wr_ok     = bus.wr_en & ({1'b0, bus.wr_mat} < MAT_LIM)
                                  & ({1'b0, bus.wr_col} < COL_LIM);

   // one-hot column enable for the current slot, bit m*N_COLS+c
   always_comb begin
      w_col_sel = '0;
      for (int m = 0; m < N_MAT; m++) begin
         for (int c = 0; c < N_COLS; c++) begin
            if ((r_slot_mat == MW'(m)) && (r_slot_col == CW'(c))) begin
               w_col_sel[m*N_COLS + c] = 1'b1;
            end else begin
               w_col_sel[m*N_COLS + c] = 1'b0;
            end
         end
      end
   end

   // active-low row pattern for the current slot from the front buffer
   always_comb begin
      w_row_next = '1;
      w_row_next = ~r_buf[r_front][r_slot_mat][r_slot_col];
   end

   // prescaler, slot position and blank counter; all frozen while disabled,
   // except the blank counter which restarts so a resumed slot blanks again
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc    <= '0;
         r_slot_mat <= '0;
         r_slot_col <= '0;
         r_bcnt     <= '0;
      end else if (bus.enable) begin
         if (w_tick) begin
            r_presc <= '0;
            r_bcnt  <= '0;
            if (w_mat_wrap) begin
               r_slot_mat <= '0;
               r_slot_col <= (r_slot_col == COL_MAX) ? CW'(0) : r_slot_col + CW'(1);
            end else begin
               r_slot_mat <= r_slot_mat + MW'(1);
            end
         end else begin
            r_presc <= r_presc + PW'(1);
            if (r_bcnt < BLANK_LIM) begin
               r_bcnt <= r_bcnt + BW'(1);
            end
         end
      end else begin
         r_bcnt <= '0;
      end
   end

   // front/back selection and merged swap request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_front <= 1'b0;
         r_pend  <= 1'b0;
      end else if (w_do_swap) begin
         r_front <= ~r_front;
         r_pend  <= 1'b0;
      end else if (bus.swap_req) begin
         r_pend  <= 1'b1;
      end
   end

   // back-buffer writes; the target is the buffer that is back before this
   // edge, so a write coinciding with a swap appears in the new front
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int m = 0; m < N_MAT; m++) begin
               for (int c = 0; c < N_COLS; c++) begin
                  r_buf[b][m][c] <= '0;
               end
            end
         end
      end else if (w_wr_ok) begin
         r_buf[~r_front][bus.wr_mat][bus.wr_col] <= bus.wr_data;
      end
   end

   // registered pin drivers and status pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row         <= '1;
         r_col_en      <= '0;
         r_swap_ack    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_row         <= w_lit ? w_row_next : '1;
         r_col_en      <= w_lit ? w_col_sel  : '0;
         r_swap_ack    <= w_do_swap;
         r_frame_start <= w_frame_end;
      end
   end

   assign bus.row         = r_row;
   assign bus.col         = r_col_en;
   assign bus.swap_ack    = r_swap_ack;
   assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner (2 matrices x 3 columns, 4-cycle slots).
module tb_led_matrix_scanner;
   localparam int N_MAT = 2, N_COLS = 3, N_ROWS = 8, TICK_DIV = 4, BLANK_CYC = 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   led_matrix_scanner_if #(.N_MAT(N_MAT), .N_COLS(N_COLS), .N_ROWS(N_ROWS)) bus ();

   led_matrix_scanner #(
      .N_MAT(N_MAT), .N_COLS(N_COLS), .N_ROWS(N_ROWS),
      .TICK_DIV(TICK_DIV), .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model of the scanner: state at the start of the next cycle
   logic [7:0] m_buf [0:1][0:1][0:2];
   int m_presc, m_mat, m_col, m_bcnt, m_front, m_pend;
   // outputs expected at the sample following the last step
   logic [7:0] e_row;
   logic [5:0] e_col;
   logic       e_ack, e_fs;

   // hand-computed scan table for test_frame_scan (slot order m0c0,m1c0,m0c1,...)
   int         h_wm   [0:5] = '{0, 1, 0, 1, 0, 1};
   int         h_wc   [0:5] = '{0, 0, 1, 1, 2, 2};
   logic [7:0] h_data [0:5] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h0F, 8'hF0};
   logic [7:0] h_row  [0:5] = '{8'h7E, 8'hBD, 8'hDB, 8'hE7, 8'hF0, 8'h0F};
   logic [5:0] h_col  [0:5] = '{6'b000001, 6'b001000, 6'b000010,
                                6'b010000, 6'b000100, 6'b100000};

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int m = 0; m < 2; m++)
            for (int c = 0; c < 3; c++)
               m_buf[b][m][c] = 8'h00;
      m_presc = 0; m_mat = 0; m_col = 0; m_bcnt = 0; m_front = 0; m_pend = 0;
      e_row = 8'hFF; e_col = 6'b000000; e_ack = 1'b0; e_fs = 1'b0;
   endtask

   // drive one cycle of inputs at a falling edge, advance the model, and
   // return at the next falling edge where the DUT outputs are sampled
   task automatic step(input logic en, input logic we, input int wm, input int wc,
                       input logic [7:0] wd, input logic sr);
      logic lit, tick, fe;
      bus.enable   = en;
      bus.wr_en    = we;
      bus.wr_mat   = wm[0:0];
      bus.wr_col   = wc[1:0];
      bus.wr_data  = wd;
      bus.swap_req = sr;
      lit   = en && (m_bcnt >= BLANK_CYC);
      e_col = lit ? (6'b000001 << (m_mat * N_COLS + m_col)) : 6'b000000;
      e_row = lit ? ~m_buf[m_front][m_mat][m_col] : 8'hFF;
      tick  = en && (m_presc == TICK_DIV - 1);
      fe    = tick && (m_mat == N_MAT - 1) && (m_col == N_COLS - 1);
      e_fs  = fe;
      e_ack = fe && (m_pend != 0 || sr);
      if (we && wm < N_MAT && wc < N_COLS) m_buf[1 - m_front][wm][wc] = wd;
      if (e_ack) begin m_front = 1 - m_front; m_pend = 0; end
      else if (sr) m_pend = 1;
      if (!en) m_bcnt = 0;
      else if (tick) begin
         m_presc = 0; m_bcnt = 0;
         if (m_mat == N_MAT - 1) begin
            m_mat = 0;
            m_col = (m_col == N_COLS - 1) ? 0 : m_col + 1;
         end else m_mat = m_mat + 1;
      end else begin
         m_presc = m_presc + 1;
         if (m_bcnt < BLANK_CYC) m_bcnt = m_bcnt + 1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_mat = 1'b0; bus.wr_col = 2'd0;
      bus.wr_data = 8'h00; bus.swap_req = 1'b0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      n_vec++; if (bus.row !== 8'hFF) begin n_err++; $display("FAIL reset_row got %h want ff", bus.row); end
      n_vec++; if (bus.col !== 6'b000000) begin n_err++; $display("FAIL reset_col got %b want 000000", bus.col); end
      n_vec++; if (bus.swap_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", bus.swap_ack); end
      n_vec++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
      reset = 1'b0;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      n_vec++; if (bus.col !== 6'b001000) begin n_err++; $display("FAIL pre_reset_col got %b want 001000", bus.col); end
      // assert reset between clock edges, mid-slot
      #2 reset = 1'b1;
      #1;
      n_vec++; if (bus.row !== 8'hFF) begin n_err++; $display("FAIL async_row got %h want ff", bus.row); end
      n_vec++; if (bus.col !== 6'b000000) begin n_err++; $display("FAIL async_col got %b want 000000", bus.col); end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      n_vec++; if (bus.col !== 6'b000000) begin n_err++; $display("FAIL first_blank got %b want 000000", bus.col); end
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      n_vec++; if (bus.col !== 6'b000001) begin n_err++; $display("FAIL first_lit_col got %b want 000001", bus.col); end
      n_vec++; if (bus.row !== 8'hFF) begin n_err++; $display("FAIL first_lit_row got %h want ff", bus.row); end
   endtask

   task automatic test_frame_scan();
      logic found;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, h_wm[i], h_wc[i], h_data[i], 1'b0);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, i == 0);
         n_vec++; if (bus.frame_start !== e_fs) begin n_err++; $display("FAIL scan_fs got %b want %b", bus.frame_start, e_fs); end
         found = e_fs;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL scan_timeout got no frame end want frame end"); end
      n_vec++; if (bus.swap_ack !== 1'b1) begin n_err++; $display("FAIL scan_ack got %b want 1", bus.swap_ack); end
      for (int s = 0; s < 6; s++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
         n_vec++; if (bus.col !== 6'b000000 || bus.row !== 8'hFF) begin
            n_err++; $display("FAIL scan_blank slot %0d got col %b row %h want 000000 ff", s, bus.col, bus.row); end
         for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
            n_vec++; if (bus.col !== h_col[s] || bus.row !== h_row[s]) begin
               n_err++; $display("FAIL scan_lit slot %0d got col %b row %h want %b %h", s, bus.col, bus.row, h_col[s], h_row[s]); end
         end
      end
   endtask

   task automatic test_swap_merge();
      int  acks;
      logic found;
      acks = 0; found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, (i == 2) || (i == 8));
         if (bus.swap_ack === 1'b1) acks++;
         n_vec++; if (bus.row !== e_row || bus.col !== e_col) begin
            n_err++; $display("FAIL merge_out got %h/%b want %h/%b", bus.row, bus.col, e_row, e_col); end
         found = e_fs;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL merge_timeout got no frame end want frame end"); end
      n_vec++; if (acks != 1) begin n_err++; $display("FAIL merge_ack_count got %0d want 1", acks); end
      n_vec++; if (bus.swap_ack !== 1'b1 || bus.frame_start !== 1'b1) begin
         n_err++; $display("FAIL merge_align got ack %b fs %b want 1 1", bus.swap_ack, bus.frame_start); end
      // request arriving on the frame-end cycle itself
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (m_presc == TICK_DIV - 1 && m_mat == N_MAT - 1 && m_col == N_COLS - 1) found = 1'b1;
         else step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      end
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b1);
      n_vec++; if (bus.swap_ack !== 1'b1) begin n_err++; $display("FAIL late_req_ack got %b want 1", bus.swap_ack); end
      n_vec++; if (bus.frame_start !== 1'b1) begin n_err++; $display("FAIL late_req_fs got %b want 1", bus.frame_start); end
   endtask

   task automatic test_write_guard();
      int   hits, stray;
      logic found;
      step(1'b1, 1'b1, 1, 3, 8'hFF, 1'b0);   // column 3 does not exist
      step(1'b1, 1'b1, 0, 0, 8'h55, 1'b0);   // back buffer only, no swap
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
         n_vec++; if (bus.row !== e_row || bus.col !== e_col) begin
            n_err++; $display("FAIL guard_sync got %h/%b want %h/%b", bus.row, bus.col, e_row, e_col); end
         found = e_fs;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL guard_timeout got no frame end want frame end"); end
      hits = 0;
      for (int i = 0; i < 48; i++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
         if (bus.col === 6'b000001 && bus.row === 8'h7E) hits++;
         n_vec++; if (bus.row !== e_row || bus.col !== e_col) begin
            n_err++; $display("FAIL guard_front got %h/%b want %h/%b", bus.row, bus.col, e_row, e_col); end
      end
      n_vec++; if (hits != 6) begin n_err++; $display("FAIL guard_unchanged got %0d want 6", hits); end
      // expose the back buffer: only m0c0 = 8'h55 should light anything
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, i == 0);
         found = e_fs;
      end
      hits = 0; stray = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
         if (bus.col === 6'b000001 && bus.row === 8'hAA) hits++;
         else if (bus.row !== 8'hFF) stray++;
      end
      n_vec++; if (hits != 3) begin n_err++; $display("FAIL guard_back_hit got %0d want 3", hits); end
      n_vec++; if (stray != 0) begin n_err++; $display("FAIL guard_back_stray got %0d want 0", stray); end
   endtask

   task automatic test_enable_hold();
      logic [5:0] held;
      for (int i = 0; i < 10 && m_presc != 2; i++) step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      held = 6'b000001 << (m_mat * N_COLS + m_col);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
         n_vec++; if (bus.col !== 6'b000000 || bus.row !== 8'hFF) begin
            n_err++; $display("FAIL hold_blank cyc %0d got %b %h want 000000 ff", i, bus.col, bus.row); end
      end
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      n_vec++; if (bus.col !== 6'b000000) begin n_err++; $display("FAIL resume_blank got %b want 000000", bus.col); end
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      n_vec++; if (bus.col !== held || bus.row !== e_row) begin
         n_err++; $display("FAIL resume_lit got %b %h want %b %h", bus.col, bus.row, held, e_row); end
      step(1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
      n_vec++; if (bus.col !== 6'b000000) begin n_err++; $display("FAIL resume_next_blank got %b want 000000", bus.col); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 100 * 24; i++) begin
         step(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 3),
              8'($urandom), $urandom_range(0, 15) == 0);
         n_vec++; if (!$onehot0(bus.col)) begin n_err++; $display("FAIL rand_onehot cyc %0d got %b want one-hot or zero", i, bus.col); end
         n_vec++; if (bus.col !== e_col) begin n_err++; $display("FAIL rand_col cyc %0d got %b want %b", i, bus.col, e_col); end
         n_vec++; if (bus.row !== e_row) begin n_err++; $display("FAIL rand_row cyc %0d got %h want %h", i, bus.row, e_row); end
         n_vec++; if (bus.swap_ack !== e_ack || bus.frame_start !== e_fs) begin
            n_err++; $display("FAIL rand_pulse cyc %0d got %b%b want %b%b", i, bus.swap_ack, bus.frame_start, e_ack, e_fs); end
      end
   endtask

   initial begin
      test_reset();
      test_frame_scan();
      test_swap_merge();
      test_write_guard();
      test_enable_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
